// File: rtl/fu_arith_issue_arb.sv
`default_nettype none
// ============================================================================
// Module      : fu_arith_issue_arb
// Description : Round-robin issue arbiter sharing one fu_arith unit between
//               NUM_REQ reservation-station requesters through a one-entry
//               issue register. Optional per-requester performance counters
//               are enabled by defining FU_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fu_arith_issue_arb #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int PRN_W   = 7,
    parameter int ID_W    = 6,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    output logic [NUM_REQ-1:0]      o_req_ready,
    input  logic [NUM_REQ*32-1:0]   i_req_inst,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_op0,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_op1,
    input  logic [NUM_REQ*PRN_W-1:0] i_req_prn,
    input  logic [NUM_REQ*ID_W-1:0] i_req_inst_id,
    input  logic                    i_flush,
    input  logic                    i_fu_ready,
    output logic                    o_fu_inst_valid,
    output logic [31:0]             o_fu_inst,
    output logic [DATA_W-1:0]       o_fu_op0,
    output logic [DATA_W-1:0]       o_fu_op1,
    output logic [PRN_W-1:0]        o_fu_out_prn,
    output logic [ID_W-1:0]         o_fu_inst_id,
    output logic [IDX_W-1:0]        o_grant_idx,
    output logic [NUM_REQ*32-1:0]   o_stat_grants,
    output logic [31:0]             o_stat_stall
);

    localparam logic [IDX_W:0]   c_NUM_EXT = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] c_LAST    = IDX_W'(NUM_REQ - 1);

    logic                r_valid;
    logic [31:0]         r_inst;
    logic [DATA_W-1:0]   r_op0;
    logic [DATA_W-1:0]   r_op1;
    logic [PRN_W-1:0]    r_prn;
    logic [ID_W-1:0]     r_id;
    logic [IDX_W-1:0]    r_grant_idx;
    logic [IDX_W-1:0]    r_rr_ptr;

    logic                w_can_accept;
    logic                w_found;
    logic                w_grant;
    logic [IDX_W-1:0]    w_sel;
    logic [IDX_W-1:0]    w_idx;
    logic [IDX_W:0]      w_sum;
    logic [IDX_W-1:0]    w_next_ptr;

    // Round-robin search from r_rr_ptr upward (mod NUM_REQ) for the first valid requester
    always_comb begin
        w_can_accept = ~i_flush & (~r_valid | i_fu_ready);
        w_found      = 1'b0;
        w_sel        = '0;
        w_sum        = '0;
        w_idx        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_sum >= c_NUM_EXT) begin
                w_sum = w_sum - c_NUM_EXT;
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
        // Held in reset the flops are already cleared, but requesters must not see a grant
        w_grant     = w_can_accept & w_found & ~rst;
        o_req_ready = '0;
        if (w_grant) begin
            o_req_ready[w_sel] = 1'b1;
        end
        w_next_ptr = (w_sel == c_LAST) ? '0 : w_sel + 1'b1;
    end

    // Issue register: flush clears, a grant loads (replacing a consumed entry), consume clears, stall holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_inst      <= '0;
            r_op0       <= '0;
            r_op1       <= '0;
            r_prn       <= '0;
            r_id        <= '0;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (w_grant) begin
            r_valid     <= 1'b1;
            r_inst      <= i_req_inst[w_sel*32 +: 32];
            r_op0       <= i_req_op0[w_sel*DATA_W +: DATA_W];
            r_op1       <= i_req_op1[w_sel*DATA_W +: DATA_W];
            r_prn       <= i_req_prn[w_sel*PRN_W +: PRN_W];
            r_id        <= i_req_inst_id[w_sel*ID_W +: ID_W];
            r_grant_idx <= w_sel;
            r_rr_ptr    <= w_next_ptr;
        end else if (r_valid && i_fu_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_fu_inst_valid = r_valid;
    assign o_fu_inst       = r_inst;
    assign o_fu_op0        = r_op0;
    assign o_fu_op1        = r_op1;
    assign o_fu_out_prn    = r_prn;
    assign o_fu_inst_id    = r_id;
    assign o_grant_idx     = r_grant_idx;

`ifdef FU_ARB_STATS_EN
    logic [31:0] r_stat_stall;

    // Saturating count of cycles where the FU refuses a valid entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_stall <= '0;
        end else if (r_valid && !i_fu_ready && !i_flush && r_stat_stall != 32'hFFFF_FFFF) begin
            r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign o_stat_stall = r_stat_stall;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat_grant
        logic [31:0] r_cnt;

        // Saturating count of grants to this requester
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_grant && w_sel == IDX_W'(g) && r_cnt != 32'hFFFF_FFFF) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end

        assign o_stat_grants[g*32 +: 32] = r_cnt;
    end
`else
    assign o_stat_grants = '0;
    assign o_stat_stall  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fu_arith_issue_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fu_arith_issue_arb
// Description : Directed self-checking bench for fu_arith_issue_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fu_arith_issue_arb;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 64;
    localparam int PRN_W   = 7;
    localparam int ID_W    = 6;
`ifdef FU_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*32-1:0]     req_inst;
    logic [NUM_REQ*DATA_W-1:0] req_op0;
    logic [NUM_REQ*DATA_W-1:0] req_op1;
    logic [NUM_REQ*PRN_W-1:0]  req_prn;
    logic [NUM_REQ*ID_W-1:0]   req_id;
    logic                      flush = 1'b0;
    logic                      fu_ready = 1'b1;
    logic                      fu_inst_valid;
    logic [31:0]               fu_inst;
    logic [DATA_W-1:0]         fu_op0;
    logic [DATA_W-1:0]         fu_op1;
    logic [PRN_W-1:0]          fu_out_prn;
    logic [ID_W-1:0]           fu_inst_id;
    logic [1:0]                grant_idx;
    logic [NUM_REQ*32-1:0]     stat_grants;
    logic [31:0]               stat_stall;

    logic [31:0]       inst_a [NUM_REQ];
    logic [DATA_W-1:0] op0_a  [NUM_REQ];
    logic [DATA_W-1:0] op1_a  [NUM_REQ];

    int n_cmp = 0;
    int n_bad = 0;

    fu_arith_issue_arb #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .PRN_W(PRN_W), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_inst(req_inst), .i_req_op0(req_op0), .i_req_op1(req_op1),
        .i_req_prn(req_prn), .i_req_inst_id(req_id),
        .i_flush(flush), .i_fu_ready(fu_ready),
        .o_fu_inst_valid(fu_inst_valid), .o_fu_inst(fu_inst),
        .o_fu_op0(fu_op0), .o_fu_op1(fu_op1),
        .o_fu_out_prn(fu_out_prn), .o_fu_inst_id(fu_inst_id),
        .o_grant_idx(grant_idx),
        .o_stat_grants(stat_grants), .o_stat_stall(stat_stall)
    );

    always #5 clk = ~clk;

    // Pack per-requester fields; prn = 10+i, id = 20+i
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_inst[i*32 +: 32]        = inst_a[i];
            req_op0[i*DATA_W +: DATA_W] = op0_a[i];
            req_op1[i*DATA_W +: DATA_W] = op1_a[i];
            req_prn[i*PRN_W +: PRN_W]   = PRN_W'(10 + i);
            req_id[i*ID_W +: ID_W]      = ID_W'(20 + i);
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        @(posedge clk); #1;
        n_cmp++; if (fu_inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", fu_inst_valid); end
        n_cmp++; if (fu_inst !== 32'h0 || grant_idx !== 2'd0) begin n_bad++; $display("FAIL reset_regs inst=%h idx=%0d exp=0/0", fu_inst, grant_idx); end
        n_cmp++; if (stat_grants !== '0 || stat_stall !== 32'h0) begin n_bad++; $display("FAIL reset_stats grants=%h stall=%0d exp=0", stat_grants, stat_stall); end
        @(negedge clk);
        req_valid = 4'b0000;
        rst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 4'b0001; fu_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        n_cmp++; if (fu_inst_valid !== 1'b1 || fu_inst !== 32'h9100_0421 || grant_idx !== 2'd0)
            begin n_bad++; $display("FAIL single_issue v=%b inst=%h idx=%0d exp=1/91000421/0", fu_inst_valid, fu_inst, grant_idx); end
        n_cmp++; if (fu_op0 !== op0_a[0] || fu_op1 !== op1_a[0] || fu_out_prn !== 7'd10 || fu_inst_id !== 6'd20)
            begin n_bad++; $display("FAIL single_fields op0=%h op1=%h prn=%0d id=%0d", fu_op0, fu_op1, fu_out_prn, fu_inst_id); end
        @(posedge clk); #1;
        n_cmp++; if (fu_inst_valid !== 1'b0) begin n_bad++; $display("FAIL single_consume got=%b exp=0", fu_inst_valid); end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        req_valid = 4'b1111; fu_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++; if (req_ready !== 4'(1 << (k % 4))) begin n_bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, 4'(1 << (k % 4))); end
            @(posedge clk); #1;
            n_cmp++; if (fu_inst_valid !== 1'b1 || grant_idx !== 2'(k % 4) || fu_inst !== inst_a[k % 4])
                begin n_bad++; $display("FAIL rr_issue[%0d] v=%b idx=%0d inst=%h exp idx=%0d", k, fu_inst_valid, grant_idx, fu_inst, k % 4); end
            @(negedge clk);
        end
        req_valid = 4'b0000;
        @(posedge clk); #1;
        n_cmp++; if (fu_inst_valid !== 1'b0) begin n_bad++; $display("FAIL rr_drain got=%b exp=0", fu_inst_valid); end
    endtask

    task automatic test_stall();
        @(negedge clk);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'b1111; fu_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_ready[%0d] got=%b exp=0000", k, req_ready); end
            @(posedge clk); #1;
            n_cmp++; if (fu_inst_valid !== 1'b1 || fu_inst !== inst_a[2] || grant_idx !== 2'd2 || fu_out_prn !== 7'd12)
                begin n_bad++; $display("FAIL stall_hold[%0d] v=%b inst=%h idx=%0d prn=%0d", k, fu_inst_valid, fu_inst, grant_idx, fu_out_prn); end
            @(negedge clk);
        end
        n_cmp++; if (stat_stall !== (STATS ? 32'd3 : 32'd0)) begin n_bad++; $display("FAIL stall_count got=%0d exp=%0d", stat_stall, STATS ? 3 : 0); end
        n_cmp++; if (stat_grants[2*32 +: 32] !== (STATS ? 32'd3 : 32'd0)) begin n_bad++; $display("FAIL stall_grants2 got=%0d exp=%0d", stat_grants[2*32 +: 32], STATS ? 3 : 0); end
        fu_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL stall_release got=%b exp=1000", req_ready); end
        @(posedge clk); #1;
        n_cmp++; if (grant_idx !== 2'd3 || fu_inst !== inst_a[3]) begin n_bad++; $display("FAIL stall_next idx=%0d exp=3", grant_idx); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        flush = 1'b1; req_valid = 4'b1111; fu_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL flush_ready got=%b exp=0000", req_ready); end
        @(posedge clk); #1;
        n_cmp++; if (fu_inst_valid !== 1'b0) begin n_bad++; $display("FAIL flush_clear got=%b exp=0", fu_inst_valid); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL flush_ptr got=%b exp=0001", req_ready); end
        @(posedge clk); #1;
        n_cmp++; if (fu_inst_valid !== 1'b1 || grant_idx !== 2'd0) begin n_bad++; $display("FAIL flush_after v=%b idx=%0d exp=1/0", fu_inst_valid, grant_idx); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        fu_ready = 1'b0; req_valid = 4'b1111;
        #2;
        n_cmp++; if (fu_inst_valid !== 1'b1) begin n_bad++; $display("FAIL arst_pre got=%b exp=1", fu_inst_valid); end
        rst = 1'b1;
        #1;
        n_cmp++; if (fu_inst_valid !== 1'b0 || fu_inst !== 32'h0 || req_ready !== 4'b0000)
            begin n_bad++; $display("FAIL arst_now v=%b inst=%h ready=%b exp=0/0/0000", fu_inst_valid, fu_inst, req_ready); end
        @(negedge clk);
        rst = 1'b0; fu_ready = 1'b1; req_valid = 4'b1010;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL arst_grant got=%b exp=0010", req_ready); end
        @(posedge clk); #1;
        n_cmp++; if (grant_idx !== 2'd1 || fu_inst !== inst_a[1]) begin n_bad++; $display("FAIL arst_issue idx=%0d exp=1", grant_idx); end
        @(negedge clk);
        req_valid = 4'b0000;
    endtask

    task automatic test_stats();
        pulse_reset();
        req_valid = 4'b0100; fu_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        req_valid = 4'b0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            n_cmp++;
            if (stat_grants[i*32 +: 32] !== ((STATS && i == 2) ? 32'd10 : 32'd0))
                begin n_bad++; $display("FAIL stat_grants[%0d] got=%0d exp=%0d", i, stat_grants[i*32 +: 32], (STATS && i == 2) ? 10 : 0); end
        end
        n_cmp++; if (stat_stall !== 32'd0) begin n_bad++; $display("FAIL stat_stall_zero got=%0d exp=0", stat_stall); end
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            inst_a[i] = 32'hA000_0000 | 32'(i);
            op0_a[i]  = 64'h1111_0000_0000_0000 + 64'(i);
            op1_a[i]  = 64'h2222_0000_0000_0000 + 64'(i);
        end
        inst_a[0] = 32'h9100_0421;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flush();
        test_async_reset();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fu_arith_issue_arb.md
# fu_arith_issue_arb

Issue arbiter that shares one `fu_arith` functional unit between `NUM_REQ` reservation-station requesters. Each cycle it selects at most one ready requester by round-robin, latches the selected instruction, operands, destination PRN and instruction ID into a one-entry issue register, and presents that register to the FU. It absorbs FU backpressure, supports pipeline flush, and optionally keeps per-requester performance counters.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 64, operand width
- `PRN_W`, 7, physical register number width
- `ID_W`, 6, instruction ID width
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: reset, asynchronous, active-high
- `req_valid` in NUM_REQ: requester i has an instruction
- `req_ready` out NUM_REQ: grant to requester i, one-hot or zero
- `req_inst` in NUM_REQ×32: instruction word per requester
- `req_op0`, `req_op1` in NUM_REQ×DATA_W: source operands (Xn, Xm)
- `req_prn` in NUM_REQ×PRN_W: destination PRN
- `req_inst_id` in NUM_REQ×ID_W: instruction ID
- `flush` in 1: discard the issue register and block grants this cycle
- `fu_ready` in 1: FU accepts the presented instruction
- `fu_inst_valid` out 1: issue register valid
- `fu_inst` out 32, `fu_op0`/`fu_op1` out DATA_W, `fu_out_prn` out PRN_W, `fu_inst_id` out ID_W: issue register contents
- `grant_idx` out $clog2(NUM_REQ): requester index of the current issue register contents
- `stat_grants` out NUM_REQ×32: grants per requester
- `stat_stall` out 32: cycles with `fu_inst_valid & ~fu_ready`

## Operation
- `can_accept = ~flush & (~fu_inst_valid | fu_ready)`.
- Round-robin pointer `rr_ptr`. When `can_accept` is high, the granted requester is the first i with `req_valid[i]` set, scanning from `rr_ptr` upward modulo NUM_REQ. `req_ready` is one-hot at that i. It is all-zero when `can_accept` is low or no request is valid.
- `req_ready` is combinational from `req_valid`, `flush`, `fu_ready`, `fu_inst_valid` and `rr_ptr`. Requesters must not make `req_valid` depend on `req_ready`.
- On a grant to i:
  - The issue register loads requester i's fields.
  - `grant_idx` loads i.
  - `rr_ptr` loads (i+1) mod NUM_REQ.
- No grant while `fu_inst_valid & fu_ready` is high: the register clears valid and `rr_ptr` holds.
- `fu_inst_valid & ~fu_ready`: the register and all its fields hold unchanged.
- Consume and grant in the same cycle: the new entry replaces the old one with no bubble.
- `flush`:
  - The register clears valid next cycle.
  - There is no grant that cycle.
  - `rr_ptr` holds.
  - `flush` overrides `fu_ready`.
- The block performs no instruction decode. Undecodable instructions pass through unchanged.
- Reset values (asynchronous):
  - `fu_inst_valid`=0, `rr_ptr`=0, `grant_idx`=0.
  - `fu_inst`, `fu_op0`, `fu_op1`, `fu_out_prn`, `fu_inst_id` = 0.
  - All stat counters = 0.
  - `req_ready` = 0 while `rst` is asserted.
- Reset asserted mid-operation drops any pending issue entry. The requester is not notified. The ROB flush path recovers it.

## Timing
- Acceptance in cycle t (`req_valid[i] & req_ready[i]` at edge t) gives `fu_inst_valid`=1 with i's fields from cycle t+1. Latency is 1.
- Sustained throughput is one instruction per cycle while `fu_ready`=1.
- Outputs change only on `clk` edges or on `rst` assertion.

## Configuration
- Macro: `FU_ARB_STATS_EN`.
- When defined:
  - `stat_grants[i]` increments on every grant to i.
  - `stat_stall` increments on every cycle with `fu_inst_valid & ~fu_ready & ~flush`.
  - Counters are 32-bit, saturating at 0xFFFFFFFF, cleared only by `rst`.
- When undefined:
  - The stat ports remain in the interface and are driven constant 0.
  - No counter flops are synthesized.
  - Arbitration behaviour is identical in both builds.

## Test plan
- Reset, then `req_valid`=4'b0001 with `req_inst`=0x91000421 -> `req_ready`=4'b0001. Next cycle `fu_inst_valid`=1, `fu_inst`=0x91000421, `grant_idx`=0.
- All four requesters valid for 8 cycles with `fu_ready`=1 -> grants in order 0,1,2,3,0,1,2,3, one per cycle, no bubbles.
- Issue register valid and `fu_ready`=0 for 3 cycles -> `req_ready`=0 and FU outputs stable for all 3 cycles. With `FU_ARB_STATS_EN`, `stat_stall`=3.
- `flush`=1 while the issue register is valid and `req_valid`=4'b1111 -> `req_ready`=0 that cycle. Next cycle `fu_inst_valid`=0 and `rr_ptr` is unchanged, so the next grant goes to the same index as without the flush.
- `rst` asserted asynchronously between edges while `fu_inst_valid`=1 -> `fu_inst_valid`=0 immediately. After release, the first grant with `req_valid`=4'b1010 goes to requester 1.
- With `FU_ARB_STATS_EN`, 10 grants to requester 2 -> `stat_grants[2]`=10 and the other counters 0. Without the macro, all stat outputs are 0.
